// File: rtl/cg_iter_engine_pkg.sv
// Shared types and constants for the cg_iter_engine solver datapath.
// Holds the FSM state encoding, the default data width and the reset
// values loaded into the A matrix and the x vector.
package cg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MXV,
        VXV,
        DONE,
        HALT
    } state_t;

    localparam int DW_DEFAULT = 32;

    localparam int unsigned A_RESET = 1;
    localparam int unsigned X_RESET = 1;

endpackage

// File: rtl/cg_iter_engine_if.sv
// Sequencer handshake between the external sequencer (master) and the
// cg_iter_engine (slave): two run/clear controls in, finish/halt out.
// Optional macro CG_STATUS_EN adds dot_result and iter_count outputs.
interface cg_iter_engine_if
`ifdef CG_STATUS_EN
    #(
        parameter int DW = 32,
        parameter int IW = 2
    )
`endif
    ;

    logic reset_vXv1;
    logic reset_mXv1;
    logic finish;
    logic halt;
`ifdef CG_STATUS_EN
    logic [DW-1:0] dot_result;
    logic [IW-1:0] iter_count;
`endif

`ifdef CG_STATUS_EN
    modport master (
        output reset_vXv1,
        output reset_mXv1,
        input  finish,
        input  halt,
        input  dot_result,
        input  iter_count
    );

    modport slave (
        input  reset_vXv1,
        input  reset_mXv1,
        output finish,
        output halt,
        output dot_result,
        output iter_count
    );
`else
    modport master (
        output reset_vXv1,
        output reset_mXv1,
        input  finish,
        input  halt
    );

    modport slave (
        input  reset_vXv1,
        input  reset_mXv1,
        output finish,
        output halt
    );
`endif

endinterface

// File: rtl/cg_iter_engine_mac.sv
// cg_mac: DW-bit multiply-accumulate shared by the mXv and vXv phases.
// The product is truncated to DW bits; clear wins over enable so the
// caller can capture the final sum and zero the accumulator in one edge.
module cg_mac #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
);

    logic [DW-1:0] acc;

    assign sum = acc + a * b;

    // Accumulator register: cleared on request, otherwise takes the running sum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/cg_iter_engine.sv
// cg_iter_engine: iterative fixed-point engine, top of the solver datapath.
// Each iteration computes y = A*x (N*N cycles) then s = x.y (N cycles),
// raises finish and waits for the sequencer to restart with x <= y.
// After ITER_MAX iterations halt is raised until reset.
// Optional macro CG_STATUS_EN exposes dot_result and iter_count.
module cg_iter_engine
    import cg_pkg::*;
#(
    parameter int N        = 4,
    parameter int DW       = DW_DEFAULT,
    parameter int ITER_MAX = 3
) (
    input logic             clk,
    input logic             reset,
    cg_iter_engine_if.slave bus
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int IW    = $clog2(ITER_MAX + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t state;
    state_t state_next;

    logic [N-1:0][N-1:0][DW-1:0] a_mat;
    logic [N-1:0][DW-1:0]        x;
    logic [N-1:0][DW-1:0]        y;
    logic [DW-1:0]               s;
    logic [IW-1:0]               iter;
    logic [IDX_W-1:0]            i;
    logic [IDX_W-1:0]            j;
    logic [IDX_W-1:0]            k;
    logic                        finish_q;
    logic                        halt_q;

    logic          mac_clear;
    logic          mac_en;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [DW-1:0] mac_sum;

    cg_mac #(.DW(DW)) u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .sum   (mac_sum)
    );

    assign bus.finish = finish_q;
    assign bus.halt   = halt_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and MAC operand steering; aborts take priority over progress
    always_comb begin
        state_next = state;
        mac_clear  = 1'b1;
        mac_en     = 1'b0;
        mac_a      = '0;
        mac_b      = '0;
        case (state)
            IDLE: begin
                if (bus.reset_mXv1 && !bus.reset_vXv1) begin
                    state_next = MXV;
                end
            end
            MXV: begin
                if (!bus.reset_mXv1) begin
                    state_next = IDLE;
                end else begin
                    mac_a     = a_mat[i][j];
                    mac_b     = x[j];
                    mac_en    = 1'b1;
                    mac_clear = (j == LAST);
                    if (j == LAST && i == LAST) begin
                        state_next = VXV;
                    end
                end
            end
            VXV: begin
                if (bus.reset_vXv1) begin
                    state_next = IDLE;
                end else begin
                    mac_a     = x[k];
                    mac_b     = y[k];
                    mac_en    = 1'b1;
                    mac_clear = (k == LAST);
                    if (k == LAST) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.reset_mXv1) begin
                    state_next = (iter == IW'(ITER_MAX)) ? HALT : IDLE;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath storage, indices, iteration count and the finish/halt flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                x[r] <= DW'(X_RESET);
                for (int c = 0; c < N; c++) begin
                    a_mat[r][c] <= DW'(A_RESET);
                end
            end
            y        <= '0;
            s        <= '0;
            iter     <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            finish_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                end
                MXV: begin
                    if (bus.reset_mXv1) begin
                        if (j == LAST) begin
                            y[i] <= mac_sum;
                            j    <= '0;
                            i    <= i + IDX_W'(1);
                            if (i == LAST) begin
                                k <= '0;
                                s <= '0;
                            end
                        end else begin
                            j <= j + IDX_W'(1);
                        end
                    end
                end
                VXV: begin
                    if (bus.reset_vXv1) begin
                        s <= '0;
                    end else begin
                        s <= mac_sum;
                        if (k == LAST) begin
                            finish_q <= 1'b1;
                            iter     <= iter + IW'(1);
                        end else begin
                            k <= k + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (!bus.reset_mXv1) begin
                        x        <= y;
                        finish_q <= 1'b0;
                        if (iter == IW'(ITER_MAX)) begin
                            halt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CG_STATUS_EN
    logic [DW-1:0] dot_q;

    // Latch the finished dot product as the engine enters DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dot_q <= '0;
        end else if (state == VXV && !bus.reset_vXv1 && k == LAST) begin
            dot_q <= mac_sum;
        end
    end

    assign bus.dot_result = dot_q;
    assign bus.iter_count = iter;
`endif

endmodule

// File: tb/tb_cg_iter_engine.sv
// Directed self-checking bench for cg_iter_engine (N=4, DW=32, ITER_MAX=3).
// With A and x reset to all ones: iteration 1 gives y=4s, s=16;
// iteration 2 y=16s, s=256; iteration 3 y=64s, s=4096, then halt.
module tb_cg_iter_engine;
    import cg_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

`ifdef CG_STATUS_EN
    cg_iter_engine_if #(.DW(32), .IW(2)) bus_if ();
`else
    cg_iter_engine_if bus_if ();
`endif

    cg_iter_engine #(
        .N        (4),
        .DW       (32),
        .ITER_MAX (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mxv, input logic vxv);
        bus_if.reset_mXv1 = mxv;
        bus_if.reset_vXv1 = vxv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkY(input string tag, input logic [31:0] exp);
        for (int m = 0; m < 4; m++) begin
            checkOutput($sformatf("%s y[%0d]", tag, m), dut.y[m], exp);
        end
    endtask

    task automatic checkXOnes(input string tag);
        for (int m = 0; m < 4; m++) begin
            checkOutput($sformatf("%s x[%0d]", tag, m), dut.x[m], 32'd1);
        end
    endtask

    // Start from IDLE, measure cycles from the leaving edge to finish, check s
    task automatic runIteration(input string tag, input logic [31:0] exp_s);
        int cycles;
        applyStimulus(1'b1, 1'b0);
        step(1);
        cycles = 0;
        while (bus_if.finish !== 1'b1 && cycles < 40) begin
            step(1);
            cycles++;
        end
        checkOutput({tag, " latency"}, cycles, 32'd20);
        checkOutput({tag, " s"}, dut.s, exp_s);
`ifdef CG_STATUS_EN
        checkOutput({tag, " dot_result"}, bus_if.dot_result, exp_s);
`endif
    endtask

    // Restart protocol: run/clear low for five cycles; finish must drop after one
    task automatic restart(input string tag);
        applyStimulus(1'b0, 1'b0);
        step(1);
        checkOutput({tag, " finish low"}, 32'(bus_if.finish), 32'd0);
        step(4);
    endtask

    task automatic pulseReset();
        #2 reset = 1'b0;
        #1 reset = 1'b1;
    endtask

    // Directed sequence
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(1'b0, 1'b1);
        step(2);
        checkOutput("in reset finish", 32'(bus_if.finish), 32'd0);
        checkOutput("in reset halt", 32'(bus_if.halt), 32'd0);
        reset = 1'b1;
        step(10);
        checkOutput("idle state", 32'(dut.state), 32'(IDLE));
        checkOutput("idle finish", 32'(bus_if.finish), 32'd0);
        checkOutput("idle halt", 32'(bus_if.halt), 32'd0);
        checkOutput("reset s", dut.s, 32'd0);
        checkOutput("reset iter", 32'(dut.iter), 32'd0);
        checkXOnes("reset");
        checkY("reset", 32'd0);

        $display("[TB] start and clear together must not start");
        applyStimulus(1'b1, 1'b1);
        step(3);
        checkOutput("both high state", 32'(dut.state), 32'(IDLE));

        $display("[TB] three full iterations");
        runIteration("iter1", 32'd16);
        checkY("iter1", 32'd4);
        checkOutput("iter1 count", 32'(dut.iter), 32'd1);
`ifdef CG_STATUS_EN
        checkOutput("iter1 iter_count", 32'(bus_if.iter_count), 32'd1);
`endif
        applyStimulus(1'b1, 1'b1);
        step(2);
        checkOutput("done ignores vxv clear", 32'(bus_if.finish), 32'd1);
        restart("restart1");
        checkOutput("restart1 halt", 32'(bus_if.halt), 32'd0);
        checkOutput("restart1 x", dut.x[2], 32'd4);
        runIteration("iter2", 32'd256);
        checkY("iter2", 32'd16);
        restart("restart2");
        checkOutput("restart2 halt", 32'(bus_if.halt), 32'd0);
        runIteration("iter3", 32'd4096);
        checkOutput("iter3 y0", dut.y[0], 32'd64);
        checkOutput("iter3 count", 32'(dut.iter), 32'd3);

        applyStimulus(1'b0, 1'b0);
        step(1);
        checkOutput("halt rise", 32'(bus_if.halt), 32'd1);
        checkOutput("halt finish", 32'(bus_if.finish), 32'd0);
        checkOutput("halt state", 32'(dut.state), 32'(HALT));
        applyStimulus(1'b1, 1'b0);
        step(5);
        applyStimulus(1'b0, 1'b1);
        step(3);
        checkOutput("halt sticky", 32'(bus_if.halt), 32'd1);

        $display("[TB] async reset while halted");
        #2 reset = 1'b0;
        #1;
        checkOutput("async halt cleared", 32'(bus_if.halt), 32'd0);
        checkOutput("async finish cleared", 32'(bus_if.finish), 32'd0);
        checkOutput("async iter cleared", 32'(dut.iter), 32'd0);
        checkXOnes("async halt");
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        step(2);

        $display("[TB] mXv abort in cycle 7");
        applyStimulus(1'b1, 1'b0);
        step(1);
        step(6);
        applyStimulus(1'b0, 1'b0);
        step(1);
        checkOutput("mxv abort state", 32'(dut.state), 32'(IDLE));
        step(3);
        checkOutput("mxv abort finish", 32'(bus_if.finish), 32'd0);
        checkXOnes("mxv abort");
        runIteration("after mxv abort", 32'd16);

        $display("[TB] vXv abort in cycle 2");
        applyStimulus(1'b0, 1'b0);
        pulseReset();
        step(1);
        applyStimulus(1'b1, 1'b0);
        step(1);
        step(17);
        checkOutput("vxv partial state", 32'(dut.state), 32'(VXV));
        checkOutput("vxv partial s", dut.s, 32'd4);
        applyStimulus(1'b1, 1'b1);
        step(1);
        checkOutput("vxv abort state", 32'(dut.state), 32'(IDLE));
        checkOutput("vxv abort s", dut.s, 32'd0);
        checkOutput("vxv abort iter", 32'(dut.iter), 32'd0);
        checkOutput("vxv abort finish", 32'(bus_if.finish), 32'd0);
        runIteration("after vxv abort", 32'd16);
        checkOutput("after vxv abort iter", 32'(dut.iter), 32'd1);

        $display("[TB] async reset mid mXv");
        applyStimulus(1'b0, 1'b0);
        step(1);
        applyStimulus(1'b1, 1'b0);
        step(1);
        step(5);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid mxv reset state", 32'(dut.state), 32'(IDLE));
        checkOutput("mid mxv reset finish", 32'(bus_if.finish), 32'd0);
        checkOutput("mid mxv reset halt", 32'(bus_if.halt), 32'd0);
        checkXOnes("mid mxv reset");
        applyStimulus(1'b0, 1'b0);
        reset = 1'b1;
        step(2);
        runIteration("after mid reset", 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
